// File: rtl/mt_rng_pkg.sv
// Shared types and constants for the mt19937 burst scheduler.
// Generator word width and the post-reset seed live here so the top and bench agree.
package mt_rng_pkg;

   localparam int GEN_W = 32;
   localparam logic [GEN_W-1:0] DEF_SEED = 32'd5489;

   typedef enum logic [2:0] {
      SEED_ISSUE,
      SEED_GAP,
      SEED_WAIT,
      ARB,
      STREAM
   } state_t;

endpackage

// File: rtl/mt_rng_sched_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping; zero latency.
// No state and no backpressure; pick is one-hot, or zero when nothing is requested.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  pick,
   output logic          any_valid
);

   logic [N-1:0] rot;
   logic [N-1:0] oh;

   always_comb begin
      // Rotate so ptr lands on bit 0, take the lowest set bit, rotate back.
      rot = N'({req, req} >> ptr);
      oh  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            oh    = '0;
            oh[i] = 1'b1;
         end
      end
      pick      = N'(({oh, oh} << ptr) >> N);
      any_valid = |req;
   end

endmodule

// File: rtl/mt_rng_sched.sv
// Shares one mt19937 among NUM_REQ workers in BURST-word grants and owns generator seeding.
// Grant-to-first-valid 2 cycles, then 1 word/cycle; out_ready low on the owner stalls the generator.
module mt_rng_sched
   import mt_rng_pkg::*;
#(
   parameter int             NUM_REQ  = 4,
   parameter int             BURST    = 2,
   parameter int             W        = GEN_W,
   parameter logic [W-1:0]   DEF_SEED = W'(mt_rng_pkg::DEF_SEED)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [W-1:0]       out_data,
   output logic [NUM_REQ-1:0] out_valid,
   input  logic [NUM_REQ-1:0] out_ready,
   output logic [NUM_REQ-1:0] grant,
   input  logic               seed_req,
   input  logic [W-1:0]       seed_in,
   output logic               seed_ack,
   output logic               ready_o,
   input  logic [W-1:0]       gen_data,
   input  logic               gen_valid,
   output logic               gen_ready,
   input  logic               gen_busy,
   output logic [W-1:0]       gen_seed_val,
   output logic               gen_seed_start
);

   localparam int         PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [7:0] BURST_C = 8'(BURST);

   state_t               state, state_nx;
   logic [W-1:0]         seed;
   logic [NUM_REQ-1:0]   pick;
   logic                 any_req;
   logic [PW-1:0]        ptr, gidx, pick_idx, next_ptr;
   logic                 fresh, lane_rdy, hs, last_hs;
   logic [7:0]           issued, delivered;
   logic                 gen_valid_unused;

   // Validity comes from fresh, so stale generator words are never forwarded.
   assign gen_valid_unused = gen_valid;

   rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
      .req       (req),
      .ptr       (ptr),
      .pick      (pick),
      .any_valid (any_req)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) pick_idx = PW'(i);
      end
   end

   assign next_ptr = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
   assign lane_rdy = |(out_ready & grant);
   assign hs       = fresh & lane_rdy;
   assign last_hs  = hs && (delivered == BURST_C - 8'd1);

   always_comb begin
      state_nx  = state;
      gen_ready = 1'b0;
      seed_ack  = 1'b0;
      unique case (state)
         SEED_ISSUE: state_nx = SEED_GAP;
         SEED_GAP:   state_nx = SEED_WAIT;
         SEED_WAIT:  if (!gen_busy) state_nx = ARB;
         ARB: begin
            if (seed_req) begin
               seed_ack = 1'b1;
               state_nx = SEED_ISSUE;
            end else if (any_req) begin
               state_nx = STREAM;
            end
         end
         STREAM: begin
            gen_ready = (issued < BURST_C) && (!fresh || lane_rdy);
            if (last_hs) state_nx = ARB;
         end
         default: state_nx = SEED_ISSUE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SEED_ISSUE;
         seed      <= DEF_SEED;
         grant     <= '0;
         gidx      <= '0;
         ptr       <= '0;
         fresh     <= 1'b0;
         issued    <= '0;
         delivered <= '0;
      end else begin
         state <= state_nx;
         if (seed_ack) seed <= seed_in;
         if (state == ARB && !seed_req && any_req) begin
            grant     <= pick;
            gidx      <= pick_idx;
            issued    <= '0;
            delivered <= '0;
            fresh     <= 1'b0;
         end
         if (state == STREAM) begin
            if (gen_ready) issued <= issued + 8'd1;
            if (hs) delivered <= delivered + 8'd1;
            if (gen_ready) fresh <= 1'b1;
            else if (hs)   fresh <= 1'b0;
            if (last_hs) begin
               grant <= '0;
               ptr   <= next_ptr;
            end
         end
      end
   end

   // Reset parks the FSM in SEED_ISSUE; masking with rst_n keeps the seed strobe quiet until release.
   assign gen_seed_start = rst_n && (state == SEED_ISSUE);
   assign gen_seed_val   = gen_seed_start ? seed : '0;
   assign ready_o        = (state == ARB) || (state == STREAM);
   assign out_valid      = fresh ? grant : '0;
   assign out_data       = fresh ? gen_data : '0;

endmodule

// File: tb/tb_mt_rng_sched.sv
// Directed bench for mt_rng_sched with a behavioural mt19937 attached as the generator.
// Expected words come from an independent reference mt19937 state and a scoreboard queue.
module tb_mt_rng_sched;

   localparam int NR    = 4;
   localparam int BURST = 2;

   typedef struct packed {
      logic        vld;
      logic [3:0]  lane;
      logic [31:0] dat;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] req, out_valid, out_ready, grant;
   logic [31:0]   out_data, seed_in, gen_data, gen_seed_val;
   logic          seed_req, seed_ack, ready_o, gen_valid, gen_ready, gen_busy, gen_seed_start;

   // Instance 0 is the attached generator, instance 1 the reference for expected words.
   logic [31:0] mt [0:1][0:623];
   int          mti [0:1];
   int          busy_cnt;

   exp_t        exp_q[$];
   int          got_lane[$];
   logic [31:0] got_dat[$];
   int          got_cyc[$];
   int          checks = 0, failures = 0, seed_pulses = 0, cyc = 0;
   int          rr_order [0:4] = '{1, 2, 3, 0, 1};

   mt_rng_sched dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req            (req),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .grant          (grant),
      .seed_req       (seed_req),
      .seed_in        (seed_in),
      .seed_ack       (seed_ack),
      .ready_o        (ready_o),
      .gen_data       (gen_data),
      .gen_valid      (gen_valid),
      .gen_ready      (gen_ready),
      .gen_busy       (gen_busy),
      .gen_seed_val   (gen_seed_val),
      .gen_seed_start (gen_seed_start)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void mt_seed(input int k, input logic [31:0] s);
      mt[k][0] = s;
      for (int i = 1; i < 624; i++)
         mt[k][i] = 32'd1812433253 * (mt[k][i-1] ^ (mt[k][i-1] >> 30)) + 32'(i);
      mti[k] = 624;
   endfunction

   function automatic logic [31:0] mt_next(input int k);
      logic [31:0] y;
      if (mti[k] >= 624) begin
         for (int i = 0; i < 624; i++) begin
            y = (mt[k][i] & 32'h8000_0000) | (mt[k][(i + 1) % 624] & 32'h7fff_ffff);
            mt[k][i] = mt[k][(i + 397) % 624] ^ (y >> 1) ^ (y[0] ? 32'h9908_b0df : 32'h0);
         end
         mti[k] = 0;
      end
      y = mt[k][mti[k]];
      mti[k] = mti[k] + 1;
      y = y ^ (y >> 11);
      y = y ^ ((y << 7) & 32'h9d2c_5680);
      y = y ^ ((y << 15) & 32'hefc6_0000);
      y = y ^ (y >> 18);
      return y;
   endfunction

   // Generator model: word one cycle after gen_ready, busy for a few cycles after seed_start.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gen_busy  <= 1'b0;
         busy_cnt  <= 0;
         gen_valid <= 1'b1;
         gen_data  <= 32'hDEAD_BEEF;
      end else if (gen_seed_start) begin
         mt_seed(0, gen_seed_val);
         gen_busy <= 1'b1;
         busy_cnt <= 6;
      end else if (gen_busy) begin
         if (busy_cnt == 1) gen_busy <= 1'b0;
         busy_cnt <= busy_cnt - 1;
      end else if (gen_ready) begin
         gen_data  <= mt_next(0);
         gen_valid <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_burst(input int lane);
      exp_t e;
      for (int i = 0; i < BURST; i++) begin
         e.vld  = 1'b1;
         e.lane = 4'(lane);
         e.dat  = mt_next(1);
         exp_q.push_back(e);
      end
   endtask

   // Monitor: every handshake is popped against the scoreboard and logged.
   always @(negedge clk) begin
      exp_t e, o;
      if (rst_n) begin
         if (gen_seed_start) seed_pulses++;
         chk("valid_outside_grant", 64'(out_valid & ~grant), 64'(0));
         for (int i = 0; i < NR; i++) begin
            if (out_valid[i] && out_ready[i]) begin
               if (exp_q.size() > 0) e = exp_q.pop_front();
               else e = '0;
               o.vld  = 1'b1;
               o.lane = 4'(i);
               o.dat  = out_data;
               chk("word", 64'(o), 64'(e));
               got_lane.push_back(i);
               got_dat.push_back(out_data);
               got_cyc.push_back(cyc);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int          n, base, pulses0;
      logic [31:0] held;
      rst_n = 1'b0; req = '0; out_ready = '0; seed_req = 1'b0; seed_in = '0;
      step(2);
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_gen_ready", 64'(gen_ready), 64'(0));
      chk("rst_seed_start", 64'(gen_seed_start), 64'(0));
      chk("rst_seed_val", 64'(gen_seed_val), 64'(0));
      chk("rst_seed_ack", 64'(seed_ack), 64'(0));
      chk("rst_ready_o", 64'(ready_o), 64'(0));

      // Auto-seed after release
      rst_n = 1'b1;
      #1;
      chk("auto_seed_start", 64'(gen_seed_start), 64'(1));
      chk("auto_seed_val", 64'(gen_seed_val), 64'h1571);
      for (n = 0; n < 100 && !ready_o; n++) step(1);
      chk("ready_o_rise", 64'(n < 100), 64'(1));
      chk("seed_pulse_count", 64'(seed_pulses), 64'(1));

      // Single burst to worker 0
      mt_seed(1, 32'd5489);
      base = got_dat.size();
      expect_burst(0);
      out_ready = '1;
      req = 4'b0001;
      for (n = 0; n < 50 && got_dat.size() < base + 2; n++) step(1);
      req = '0;
      chk("burst0_done", 64'(got_dat.size()), 64'(base + 2));
      chk("burst0_w0", 64'(got_dat[base]), 64'hD091_BB5C);
      chk("burst0_w1", 64'(got_dat[base + 1]), 64'h22AE_9EF6);
      chk("burst0_back_to_back", 64'(got_cyc[base + 1] - got_cyc[base]), 64'(1));
      chk("burst0_grant_drop", 64'(grant), 64'(0));
      step(5);
      chk("burst0_no_extra", 64'(got_dat.size()), 64'(base + 2));

      // All request: pointer sits at 1 after worker 0, so order is 1,2,3,0,1
      base = got_dat.size();
      for (int k = 0; k < 5; k++) expect_burst(rr_order[k]);
      req = '1;
      for (n = 0; n < 100 && got_dat.size() < base + 10; n++) step(1);
      req = '0;
      chk("rr_done", 64'(got_dat.size()), 64'(base + 10));
      for (int k = 0; k < 10; k++) chk("rr_lane", 64'(got_lane[base + k]), 64'(rr_order[k / 2]));

      // Worker 1 with ready pattern 1,0,0,1; other lanes' ready is irrelevant
      base = got_dat.size();
      expect_burst(1);
      req = 4'b0010;
      for (n = 0; n < 50 && !out_valid[1]; n++) step(1);
      chk("stall_first_valid", 64'(out_valid), 64'(4'b0010));
      step(1);
      req = '0;
      out_ready = 4'b1101;
      #1;
      held = out_data;
      chk("stall_b_gen_ready", 64'(gen_ready), 64'(0));
      chk("stall_b_valid", 64'(out_valid), 64'(4'b0010));
      step(1);
      chk("stall_c_data_held", 64'(out_data), 64'(held));
      chk("stall_c_gen_ready", 64'(gen_ready), 64'(0));
      out_ready = 4'b1111;
      step(1);
      step(1);
      chk("stall_handshakes", 64'(got_dat.size()), 64'(base + 2));
      chk("stall_grant_drop", 64'(grant), 64'(0));

      // Reseed mid-burst on worker 2 while worker 0 also requests
      base = got_dat.size();
      expect_burst(2);
      req = 4'b0100;
      for (n = 0; n < 50 && grant != 4'b0100; n++) step(1);
      chk("seed_burst_grant", 64'(grant), 64'(4'b0100));
      mt_seed(1, 32'd1);
      expect_burst(0);
      seed_req = 1'b1;
      seed_in  = 32'd1;
      req      = 4'b0001;
      #1;
      chk("seed_ack_held_off", 64'(seed_ack), 64'(0));
      for (n = 0; n < 50 && !seed_ack; n++) step(1);
      chk("seed_ack_after_burst", 64'(got_dat.size()), 64'(base + 2));
      chk("seed_ack_no_grant", 64'(grant), 64'(0));
      step(1);
      seed_req = 1'b0;
      seed_in  = '0;
      chk("reseed_start", 64'(gen_seed_start), 64'(1));
      chk("reseed_val", 64'(gen_seed_val), 64'(1));
      chk("reseed_no_grant", 64'(grant), 64'(0));
      for (n = 0; n < 100 && got_dat.size() < base + 4; n++) step(1);
      req = '0;
      chk("reseed_done", 64'(got_dat.size()), 64'(base + 4));
      chk("reseed_lane", 64'(got_lane[base + 2]), 64'(0));
      chk("reseed_first_word", 64'(got_dat[base + 2]), 64'h6AC1_F425);

      // Reset in the middle of a stalled burst on worker 2
      out_ready = '0;
      req = 4'b0100;
      for (n = 0; n < 50 && !out_valid[2]; n++) step(1);
      chk("mid_reset_grant", 64'(grant), 64'(4'b0100));
      rst_n = 1'b0;
      #1;
      chk("mid_reset_grant_zero", 64'(grant), 64'(0));
      chk("mid_reset_valid_zero", 64'(out_valid), 64'(0));
      chk("mid_reset_data_zero", 64'(out_data), 64'(0));
      chk("mid_reset_gen_ready", 64'(gen_ready), 64'(0));
      chk("mid_reset_seed_start", 64'(gen_seed_start), 64'(0));
      chk("mid_reset_ready_o", 64'(ready_o), 64'(0));
      step(2);
      pulses0 = seed_pulses;
      mt_seed(1, 32'd5489);
      base = got_dat.size();
      expect_burst(1);
      req = 4'b0110;
      out_ready = '1;
      rst_n = 1'b1;
      #1;
      chk("post_reset_seed_val", 64'(gen_seed_val), 64'h1571);
      for (n = 0; n < 100 && got_dat.size() < base + 2; n++) step(1);
      req = '0;
      chk("post_reset_done", 64'(got_dat.size()), 64'(base + 2));
      chk("post_reset_lane", 64'(got_lane[base]), 64'(1));
      chk("post_reset_word", 64'(got_dat[base]), 64'hD091_BB5C);
      chk("post_reset_pulses", 64'(seed_pulses), 64'(pulses0 + 1));

      step(3);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
